// File: rtl/mem_responder_if.sv
// Cache/TLB memory port: the cache drives requests (master) and the memory
// responder completes them with a one-cycle m_ready pulse (slave).
interface mem_responder_if;
  logic [31:0] m_a;
  logic [31:0] m_d_w;
  logic [31:0] m_d_r;
  logic        m_access;
  logic        m_write;
  logic        m_ready;

  modport master (
    output m_a, m_d_w, m_access, m_write,
    input  m_d_r, m_ready
  );

  modport slave (
    input  m_a, m_d_w, m_access, m_write,
    output m_d_r, m_ready
  );
endinterface

// File: rtl/mem_responder.sv
// Main-memory responder: word-addressed RAM with open-row dependent latency
// and a one-cycle m_ready completion pulse followed by a turnaround cycle.
module mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int COL_BITS  = 4,
  parameter int MISS_LAT  = 6,
  parameter int HIT_LAT   = 2
) (
  input  logic            clk,
  input  logic            clrn,
  mem_responder_if.slave  mem
);

  localparam int ROW_BITS = ADDR_BITS - COL_BITS;
  localparam int DEPTH    = 1 << ADDR_BITS;
  localparam int CNT_BITS = $clog2(MISS_LAT + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LAT  = 2'd1;
  localparam logic [1:0] RDY  = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  logic [1:0]           state_r, state_nxt_s;
  logic [CNT_BITS-1:0]  cnt_r, cnt_nxt_s, lat_s;
  logic [ADDR_BITS-1:0] idx_r, idx_s;
  logic [ROW_BITS-1:0]  open_row_r, row_s;
  logic [31:0]          data_r;
  logic                 write_r;
  logic                 row_valid_r;
  logic                 hit_s;
  logic                 capture_s;
  logic                 complete_s;
  logic                 m_ready_r;
  logic [31:0]          m_d_r_r;
  logic [31:0]          ram_r [0:DEPTH-1];
  logic                 unused_bits_s;

  assign idx_s         = mem.m_a[ADDR_BITS+1:2];
  assign row_s         = idx_s[ADDR_BITS-1:COL_BITS];
  assign unused_bits_s = ^{mem.m_a[31:ADDR_BITS+2], mem.m_a[1:0]};
  assign hit_s         = row_valid_r && (row_s == open_row_r);
  assign lat_s         = hit_s ? CNT_BITS'(HIT_LAT - 1) : CNT_BITS'(MISS_LAT - 1);
  assign capture_s     = (state_r == IDLE) && mem.m_access;
  // cnt counts remaining LAT edges; the edge seeing cnt==0 is the L-th after capture.
  assign complete_s    = (state_r == LAT) && mem.m_access && (cnt_r == '0);

  // Next-state and latency counter logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (mem.m_access) begin
          state_nxt_s = LAT;
          cnt_nxt_s   = lat_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LAT: begin
        if (!mem.m_access) begin
          state_nxt_s = IDLE;
        end else if (cnt_r == '0) begin
          state_nxt_s = RDY;
        end else begin
          cnt_nxt_s = cnt_r - CNT_BITS'(1);
        end
      end
      RDY:     state_nxt_s = GAP;
      GAP:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Control state, captured request, open-row tracking and registered outputs.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      idx_r       <= '0;
      data_r      <= 32'h0;
      write_r     <= 1'b0;
      open_row_r  <= '0;
      row_valid_r <= 1'b0;
      m_ready_r   <= 1'b0;
      m_d_r_r     <= 32'h0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      m_ready_r <= complete_s;
      if (capture_s) begin
        idx_r       <= idx_s;
        data_r      <= mem.m_d_w;
        write_r     <= mem.m_write;
        open_row_r  <= row_s;
        row_valid_r <= 1'b1;
      end
      if (complete_s && !write_r) begin
        m_d_r_r <= ram_r[idx_r];
      end
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (complete_s && write_r) begin
      ram_r[idx_r] <= data_r;
    end
  end

  assign mem.m_ready = m_ready_r;
  assign mem.m_d_r   = m_d_r_r;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: each issued request pushes its expected
// completion edge and read data; the monitor pops and compares on every m_ready.
module tb_mem_responder;

  localparam int HIT  = 2;
  localparam int MISS = 6;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  mem_responder_if bus();

  mem_responder #(
    .ADDR_BITS(10),
    .COL_BITS (4),
    .MISS_LAT (MISS),
    .HIT_LAT  (HIT)
  ) dut (
    .clk (clk),
    .clrn(clrn),
    .mem (bus)
  );

  typedef struct {
    string       tag;
    int          exp_edge;
    bit          rd;
    bit          known;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model [int];
  int          n_cmp = 0;
  int          n_err = 0;
  int          edge_cnt = 0;
  int          pulses = 0;
  int          last_rdy_edge = 0;
  bit          row_valid = 1'b0;
  int          open_row = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: every m_ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (clrn === 1'b1 && bus.m_ready === 1'b1) begin
      exp_t e;
      pulses++;
      last_rdy_edge = edge_cnt;
      if (q.size() == 0) begin
        check("spurious_ready", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check({e.tag, "_lat"}, 32'(edge_cnt), 32'(e.exp_edge));
        if (e.rd && e.known) check({e.tag, "_data"}, bus.m_d_r, e.data);
      end
    end
  end

  task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input bit wr, input int cap_edge, input bit push);
    int   w;
    int   row;
    int   lat;
    exp_t e;
    w   = int'(a[11:2]);
    row = w >> 4;
    lat = (row_valid && row == open_row) ? HIT : MISS;
    row_valid = 1'b1;
    open_row  = row;
    bus.m_a      = a;
    bus.m_d_w    = d;
    bus.m_write  = wr;
    bus.m_access = 1'b1;
    if (push) begin
      e.tag      = tag;
      e.exp_edge = cap_edge + lat;
      e.rd       = !wr;
      e.known    = 1'b0;
      e.data     = 32'h0;
      if (!wr && model.exists(w)) begin
        e.known = 1'b1;
        e.data  = model[w];
      end
      q.push_back(e);
      if (wr) model[w] = d;
    end
  endtask

  task automatic start(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input bit wr, input bit push);
    issue(tag, a, d, wr, edge_cnt + 1, push);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (q.size() != 0 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (q.size() != 0) begin
      check({tag, "_timeout"}, 32'd1, 32'd0);
      q.delete();
    end
  endtask

  task automatic txn(input string tag, input logic [31:0] a, input logic [31:0] d, input bit wr);
    start(tag, a, d, wr, 1'b1);
    wait_done(tag);
    bus.m_access = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int p0;
    clrn         = 1'b0;
    bus.m_a      = 32'h0;
    bus.m_d_w    = 32'h0;
    bus.m_access = 1'b0;
    bus.m_write  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'h0, bus.m_ready}, 32'h0);
    check("rst_d_r", bus.m_d_r, 32'h0);
    @(negedge clk) clrn = 1'b1;
    @(posedge clk); #1;

    // Row-miss write then open-row hit reads.
    txn("w40", 32'h40, 32'h1234_5678, 1'b1);
    txn("r40a", 32'h40, 32'h0, 1'b0);
    txn("r40b", 32'h40, 32'h0, 1'b0);
    txn("r400", 32'h400, 32'h0, 1'b0);
    txn("r44", 32'h44, 32'h0, 1'b0);
    txn("r48", 32'h48, 32'h0, 1'b0);
    txn("alias", 32'hFFFF_F040, 32'h0, 1'b0);

    // Back-to-back with m_access held: the GAP cycle must not re-accept.
    p0 = pulses;
    start("b2b_a", 32'h40, 32'h0, 1'b0, 1'b1);
    wait_done("b2b_a");
    issue("b2b_b", 32'h400, 32'h0, 1'b0, last_rdy_edge + 3, 1'b1);
    wait_done("b2b_b");
    bus.m_access = 1'b0;
    @(posedge clk); #1;
    check("b2b_pulses", 32'(pulses - p0), 32'd2);

    // Aborted write leaves RAM and m_d_r untouched.
    txn("pre80", 32'h80, 32'h0, 1'b1);
    txn("rd40", 32'h40, 32'h0, 1'b0);
    p0 = pulses;
    start("abort", 32'h80, 32'hDEAD_BEEF, 1'b1, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_d_r", bus.m_d_r, 32'h1234_5678);
    end
    bus.m_access = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("abort_pulses", 32'(pulses - p0), 32'd0);
    check("abort_d_r_after", bus.m_d_r, 32'h1234_5678);
    txn("rd80", 32'h80, 32'h0, 1'b0);

    // Request fields are frozen after capture.
    txn("w14", 32'h14, 32'h0000_0005, 1'b1);
    start("w10", 32'h10, 32'hAAAA_5555, 1'b1, 1'b1);
    @(posedge clk); #1;
    bus.m_a     = 32'h14;
    bus.m_d_w   = 32'hFFFF_FFFF;
    bus.m_write = 1'b0;
    wait_done("w10");
    bus.m_access = 1'b0;
    @(posedge clk); #1;
    txn("rd10", 32'h10, 32'h0, 1'b0);
    txn("rd14", 32'h14, 32'h0, 1'b0);

    // Asynchronous reset during LAT kills the write and clears the row.
    txn("w20", 32'h20, 32'h1111_1111, 1'b1);
    txn("rd20", 32'h20, 32'h0, 1'b0);
    start("killed", 32'h20, 32'h3333_3333, 1'b1, 1'b0);
    @(posedge clk); #1;
    clrn = 1'b0;
    #1;
    check("rst_mid_ready", {31'h0, bus.m_ready}, 32'h0);
    check("rst_mid_d_r", bus.m_d_r, 32'h0);
    bus.m_access = 1'b0;
    row_valid    = 1'b0;
    open_row     = 0;
    @(posedge clk);
    @(negedge clk) clrn = 1'b1;
    @(posedge clk); #1;
    txn("rd20_after", 32'h20, 32'h0, 1'b0);

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
